// File: rtl/image_ram_writer.sv
// Streams one frame of DEPTH pixel words from a valid/ready source into RAM write strobes.
// Optional running checksum of the accepted words: define IMAGE_RAM_WRITER_CHECKSUM_EN.
module image_ram_writer #(
  parameter int DEPTH  = 45501,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] count_reg;
  logic              accept;
  logic              last_beat;
  logic              frame_start;

  // Abort beats acceptance so an aborted beat never reaches the RAM.
  assign accept      = in_valid && in_ready && !abort;
  assign last_beat   = (count_reg == LAST_ADDR);
  assign frame_start = (state_reg == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept && last_beat) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == LOAD);
    busy     = (state_reg == LOAD) || (state_reg == DONE);
    done     = (state_reg == DONE);
  end

  // Write port lags acceptance by one cycle, so done lines up with the final strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      aborted   <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= count_reg;
        wr_data <= in_data;
      end
      if (frame_start) begin
        count_reg <= '0;
      end else if (accept && !last_beat) begin
        count_reg <= count_reg + ADDR_W'(1);
      end
      if (frame_start) begin
        aborted <= 1'b0;
      end else if ((state_reg == LOAD) && abort) begin
        aborted <= 1'b1;
      end
    end
  end

`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg <= '0;
    end else if (frame_start) begin
      sum_reg <= '0;
    end else if (accept) begin
      sum_reg <= sum_reg + in_data;
    end
  end

  assign checksum = sum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/image_ram_writer.md
IMAGE_RAM_WRITER -- requirements
Module: image_ram_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 45501, number of 32-bit words per frame (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, default 18, width of the RAM write address.
REQ-003 SHALL have parameter DATA_W, default 32, width of the pixel word.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins a frame load.
REQ-007 SHALL have port abort, input, 1, cancels the frame in progress.
REQ-008 SHALL have port in_valid, input, 1, upstream pixel word valid.
REQ-009 SHALL have port in_data, input, DATA_W, upstream pixel word.
REQ-010 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-011 SHALL have port wr_en, output, 1, RAM write strobe.
REQ-012 SHALL have port wr_addr, output, ADDR_W, RAM write address.
REQ-013 SHALL have port wr_data, output, DATA_W, RAM write data.
REQ-014 SHALL have port busy, output, 1, frame load in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on frame completion.
REQ-016 SHALL have port aborted, output, 1, sticky flag, last frame was aborted.
REQ-017 SHALL have port checksum, output, DATA_W, frame checksum (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-019 SHALL, in IDLE, transition to LOAD on start, clearing word counter to 0, aborted to 0 and checksum to 0.
REQ-020 SHALL drive in_ready = 1 only in LOAD (combinational from state); in_valid in IDLE/DONE is not accepted.
REQ-021 SHALL define accept as in_valid && in_ready && !abort.
REQ-022 SHALL, on accept, register wr_en=1, wr_addr=counter, wr_data=in_data the next cycle (latency 1); wr_en=0 on all other cycles.
REQ-023 SHALL increment counter by 1 per accept; counter never exceeds DEPTH-1 and never wraps.
REQ-024 SHALL, on accept with counter==DEPTH-1, transition LOAD->DONE; that word is the last write.
REQ-025 SHALL, in DONE, assert done for exactly one cycle (coincident with final wr_en) and return to IDLE next cycle.
REQ-026 SHALL ignore start while busy (LOAD or DONE).
REQ-027 SHALL, on abort in LOAD, return to IDLE next cycle, set aborted=1, issue no write for that cycle's beat, and not pulse done.
REQ-028 SHALL ignore abort in IDLE and DONE; abort coincident with final accept: abort wins, no DONE.
REQ-029 SHALL drive busy = 1 in LOAD and DONE.
REQ-030 SHALL tolerate in_valid gaps of any length in LOAD without changing counter or state.

Reset
REQ-031 SHALL, on rst, enter IDLE with counter=0, wr_en=0, wr_addr=0, wr_data=0, done=0, aborted=0, checksum=0, in_ready=0, busy=0.
REQ-032 SHALL give rst priority over start and abort; reset mid-LOAD discards the frame and does not set aborted.

Configuration
REQ-033 SHALL, with macro IMAGE_RAM_WRITER_CHECKSUM_EN defined, update checksum on each accept to (checksum + in_data) mod 2^DATA_W, holding the value after DONE until next start.
REQ-034 SHALL, without IMAGE_RAM_WRITER_CHECKSUM_EN, keep the checksum port and drive it constant 0 with no adder logic.

Verification (DEPTH=4 unless stated)
REQ-035 SHALL verify basic load: start, then 4 back-to-back beats 0x11,0x22,0x33,0x44 -> wr_addr 0..3 each one cycle after accept, done pulse with addr 3, checksum 0xAA (macro on) or 0 (off).
REQ-036 SHALL verify stalls: same words with in_valid low 2 cycles between beats -> identical write sequence, no extra wr_en.
REQ-037 SHALL verify abort: abort asserted with 3rd beat -> writes only addr 0,1; aborted=1; done never pulses; next start clears aborted.
REQ-038 SHALL verify ignored inputs: in_valid high in IDLE and start during LOAD -> in_ready=0 in IDLE, no writes, counter unaffected.
REQ-039 SHALL verify reset mid-frame: rst after 2 accepts -> all outputs at reset values next cycle, aborted=0.
REQ-040 SHALL verify default DEPTH=45501: full frame of incrementing words -> last wr_addr 45500, exactly 45501 wr_en cycles, single done.
